// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Shared video RAM arbiter for screen/palette fetch, palette write
//            and CPU access, with bounded screen bursts and CPU overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int SCR_CYCLES = 2,
  parameter int UPW_CYCLES = 1,
  parameter int SCR_BURST  = 4,
  parameter int CPU_MAX    = 6
) (
  input  logic clk28,
  input  logic rst,
  input  logic i_scr_req,
  input  logic i_scr_up,
  output logic o_screen_fetch,
  output logic o_screen_fetch_up,
  output logic o_scr_ack,
  input  logic i_cpu_req,
  output logic o_cpu_grant,
  input  logic i_contention_en,
  output logic o_cpu_wait,
  input  logic i_upw_req,
  output logic o_up_write_req,
  output logic o_upw_ack,
  output logic o_overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCR  = 2'd1,
    S_UPW  = 2'd2,
    S_CPU  = 2'd3
  } state_t;

  localparam logic [2:0] c_SCR_LAST  = 3'(SCR_CYCLES - 1);
  localparam logic [2:0] c_UPW_LAST  = 3'(UPW_CYCLES - 1);
  localparam logic [3:0] c_BURST_MAX = 4'(SCR_BURST);
  localparam logic [4:0] c_CPU_MAX   = 5'(CPU_MAX);
  localparam logic [4:0] c_HOLD_SAT  = 5'd31;

  state_t     r_state, w_state_nxt, w_pick;
  logic [2:0] r_acc, w_acc_nxt;
  logic [3:0] r_burst, w_burst_nxt;
  logic [4:0] r_hold, w_hold_nxt;
  logic       r_fair, w_fair_nxt;
  logic       r_up, w_up_nxt;
  logic       r_overrun, w_overrun_nxt;
  logic       r_sf, r_sfu, r_sack, r_cg, r_uw, r_uack;
  logic       w_arb, w_burst_full, w_non_scr;

  // Arbitration point: idle, final cycle of a timed access, or CPU released.
  always_comb begin
    w_arb = (r_state == S_IDLE)
         || ((r_state == S_SCR) && (r_acc == c_SCR_LAST))
         || ((r_state == S_UPW) && (r_acc == c_UPW_LAST))
         || ((r_state == S_CPU) && !i_cpu_req);
    w_burst_full = (r_burst == c_BURST_MAX);
    w_non_scr    = i_cpu_req || i_upw_req;

    w_pick = S_IDLE;
    if (i_scr_req && !(w_burst_full && w_non_scr)) begin
      w_pick = S_SCR;
    end else if (i_cpu_req && (!i_upw_req || !r_fair)) begin
      w_pick = S_CPU;
    end else if (i_upw_req) begin
      w_pick = S_UPW;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = 3'd0;
    w_fair_nxt    = r_fair;
    w_up_nxt      = r_up;
    w_burst_nxt   = 4'd0;
    w_hold_nxt    = 5'd0;
    w_overrun_nxt = r_overrun;

    if (w_arb) begin
      w_state_nxt = w_pick;
      if ((w_pick == S_CPU) || (w_pick == S_UPW)) begin
        w_fair_nxt = ~r_fair;
      end
      if (w_pick == S_SCR) begin
        w_up_nxt = i_scr_up;
      end
    end else if ((r_state == S_SCR) || (r_state == S_UPW)) begin
      w_acc_nxt = r_acc + 3'd1;
    end

    if (w_state_nxt == S_SCR) begin
      if (!w_arb) begin
        w_burst_nxt = r_burst;
      end else if (r_state == S_SCR) begin
        w_burst_nxt = w_burst_full ? r_burst : r_burst + 4'd1;
      end else begin
        w_burst_nxt = 4'd1;
      end
    end

    if (w_state_nxt == S_CPU) begin
      if (r_state == S_CPU) begin
        w_hold_nxt = (r_hold == c_HOLD_SAT) ? r_hold : r_hold + 5'd1;
      end else begin
        w_hold_nxt = 5'd1;
      end
      if ((w_hold_nxt > c_CPU_MAX) && i_scr_req) begin
        w_overrun_nxt = 1'b1;
      end
    end
  end

  // Output flops are loaded from the next state so they line up with it.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= 3'd0;
      r_burst   <= 4'd0;
      r_hold    <= 5'd0;
      r_fair    <= 1'b0;
      r_up      <= 1'b0;
      r_overrun <= 1'b0;
      r_sf      <= 1'b0;
      r_sfu     <= 1'b0;
      r_sack    <= 1'b0;
      r_cg      <= 1'b0;
      r_uw      <= 1'b0;
      r_uack    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_burst   <= w_burst_nxt;
      r_hold    <= w_hold_nxt;
      r_fair    <= w_fair_nxt;
      r_up      <= w_up_nxt;
      r_overrun <= w_overrun_nxt;
      r_sf      <= (w_state_nxt == S_SCR);
      r_sfu     <= (w_state_nxt == S_SCR) && w_up_nxt;
      r_sack    <= (w_state_nxt == S_SCR) && (w_acc_nxt == c_SCR_LAST);
      r_cg      <= (w_state_nxt == S_CPU);
      r_uw      <= (w_state_nxt == S_UPW);
      r_uack    <= (w_state_nxt == S_UPW) && (w_acc_nxt == c_UPW_LAST);
    end
  end

  assign o_screen_fetch    = r_sf;
  assign o_screen_fetch_up = r_sfu;
  assign o_scr_ack         = r_sack;
  assign o_cpu_grant       = r_cg;
  assign o_up_write_req    = r_uw;
  assign o_upw_ack         = r_uack;
  assign o_overrun         = r_overrun;
  assign o_cpu_wait        = i_contention_en && i_cpu_req && !r_cg;

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter SCR_CYCLES, 2, clk28 cycles per screen/palette fetch access (range 1..7).
REQ-002 Parameter UPW_CYCLES, 1, clk28 cycles per palette write access (range 1..7).
REQ-003 Parameter SCR_BURST, 4, max consecutive screen accesses before a pending non-screen requester is served (range 1..15).
REQ-004 Parameter CPU_MAX, 6, CPU hold cycles beyond which a waiting screen request flags overrun (range 1..31).
REQ-005 clk28  in  1  system clock, 28 MHz; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 scr_req  in  1  level; screen byte fetch pending.
REQ-008 scr_up  in  1  qualifies scr_req as palette read; sampled on the grant edge.
REQ-009 screen_fetch  out  1  high throughout a granted screen/palette access.
REQ-010 screen_fetch_up  out  1  high with screen_fetch when the granted access is a palette read.
REQ-011 scr_ack  out  1  one-cycle pulse in the last cycle of a screen access; fetch data valid that cycle.
REQ-012 cpu_req  in  1  level; CPU RAM cycle pending (mreq, not refresh, not ROM).
REQ-013 cpu_grant  out  1  high while CPU owns the RAM bus.
REQ-014 contention_en  in  1  enables CPU wait generation.
REQ-015 cpu_wait  out  1  CPU wait request.
REQ-016 upw_req  in  1  level; palette write pending, held until acknowledged.
REQ-017 up_write_req  out  1  high throughout a granted palette write access.
REQ-018 upw_ack  out  1  one-cycle pulse in the last cycle of a palette write.
REQ-019 overrun  out  1  sticky; screen request starved by a long CPU hold.

Function
REQ-020 FSM states IDLE, SCR, UPW, CPU; state and all pulse outputs registered; outputs decoded from current state (Moore).
REQ-021 Grant latency: request high at edge N (state IDLE or arbitration point) -> state entered at edge N, outputs valid cycle after edge N (one cycle).
REQ-022 Arbitration point = IDLE, or last cycle of SCR/UPW, or CPU with cpu_req low.
REQ-023 Priority at arbitration point: scr_req first, unless burst counter equals SCR_BURST and cpu_req or upw_req pending; then non-screen.
REQ-024 Between cpu_req and upw_req: alternate via one fairness bit toggled on each non-screen grant; fairness bit 0 favours CPU.
REQ-025 No requests at arbitration point -> IDLE.
REQ-026 SCR: access counter counts SCR_CYCLES cycles; scr_ack high in last cycle; scr_req dropping mid-access does not abort; ack still issued.
REQ-027 scr_up latched on SCR entry; screen_fetch_up constant for the whole access.
REQ-028 Burst counter: +1 per SCR entry from SCR, reset to 1 on SCR entry from other state, 0 in non-SCR states; saturates at SCR_BURST.
REQ-029 UPW: lasts UPW_CYCLES; upw_ack high in last cycle; not abortable.
REQ-030 CPU: held while cpu_req high, never preempted; exits at first cycle cpu_req low, re-arbitrating that edge.
REQ-031 CPU hold counter counts cycles in CPU, saturating at 31; if count exceeds CPU_MAX while scr_req high, overrun set; cleared only by rst.
REQ-032 cpu_wait = contention_en and cpu_req and not cpu_grant (combinational from registered grant).
REQ-033 screen_fetch, up_write_req, cpu_grant mutually exclusive every cycle.
REQ-034 Simultaneous scr_req, upw_req, cpu_req from IDLE, burst 0 -> SCR.

Reset
REQ-035 rst high: state IDLE; all outputs 0; counters 0; fairness bit 0; overrun 0; effective immediately, asynchronously.
REQ-036 rst mid-access: access abandoned, no ack pulse issued; first grant earliest one cycle after rst release.

Verification
REQ-037 scr_req held 10 cycles, others low, SCR_CYCLES=2 -> screen_fetch continuous, scr_ack every 2nd cycle, 5 acks.
REQ-038 scr_req and cpu_req held, SCR_BURST=4 -> 4 screen accesses, then cpu_grant until cpu_req drops, then SCR resumes; cpu_wait high during screen burst with contention_en=1, low with contention_en=0.
REQ-039 cpu_req and upw_req held from IDLE, no scr_req -> CPU first; after cpu_req drop UPW, upw_ack one pulse; next tie goes to CPU.
REQ-040 cpu_req held 10 cycles, scr_req raised on CPU cycle 2, CPU_MAX=6 -> overrun set at cycle 7, stays 1 after all requests end; SCR granted the cycle after cpu_req drop.
REQ-041 scr_req with scr_up=1 granted, scr_up toggled mid-access -> screen_fetch_up stays 1 whole access.
REQ-042 rst asserted in SCR cycle 1 -> outputs 0 same cycle, no scr_ack; after release with scr_req high, screen_fetch one cycle later.
